// File: rtl/rv_trap_pkg.sv
// rv_trap_pkg: opcodes, CSR addresses, cause codes, CSR op codes and FSM state shared by trap_csr_ctrl and csr_file
package rv_trap_pkg;
  localparam logic [6:0] OP_LOAD = 7'd3, OP_STORE = 7'd35, OP_OP = 7'd51, OP_BRANCH = 7'd99,
                         OP_IMM = 7'd19, OP_JAL = 7'd111, OP_JALR = 7'd103, OP_LUI = 7'd55,
                         OP_AUIPC = 7'd23, OP_SYSTEM = 7'd115;
  localparam logic [11:0] CSR_MSTATUS = 12'h300, CSR_MTVEC = 12'h305, CSR_MSCRATCH = 12'h340,
                          CSR_MEPC = 12'h341, CSR_MCAUSE = 12'h342, CSR_MCYCLE = 12'hB00,
                          CSR_MINSTRET = 12'hB02;
  localparam logic [11:0] F12_ECALL = 12'h000, F12_EBREAK = 12'h001, F12_MRET = 12'h302;
  localparam int CAUSE_ILLEGAL = 2, CAUSE_BREAK = 3, CAUSE_ECALL = 11;
  localparam logic [2:0] F3_PRIV = 3'b000;
  localparam logic [1:0] CSR_RW = 2'b01, CSR_RS = 2'b10, CSR_RC = 2'b11;
  typedef enum logic [1:0] {IDLE, TRAP, REDIR, RET} state_e;
  function automatic logic legal_op(input logic [6:0] op);
    return op inside {OP_LOAD, OP_STORE, OP_OP, OP_BRANCH, OP_IMM, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_SYSTEM};
  endfunction
endpackage

// File: rtl/csr_file.sv
// csr_file: machine-mode CSR storage, read mux, RW/RS/RC write and trap/return side effects
// Ports: i_addr/i_en/i_op/i_opnd/i_zero = CSR access; i_trap/i_epc/i_cause = trap entry update;
//        i_ret = MRET update; i_retire = instret tick; o_hit = address exists; o_rdata = old value;
//        o_mtvec/o_mepc = redirect targets. Optional counters under CSR_COUNTERS_EN.
module csr_file
  import rv_trap_pkg::*;
#(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] MTVEC_RST = 'h100
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [11:0]     i_addr,
  input  logic            i_en,
  input  logic [1:0]      i_op,
  input  logic [XLEN-1:0] i_opnd,
  input  logic            i_zero,
  input  logic            i_trap,
  input  logic [XLEN-1:0] i_epc,
  input  logic [XLEN-1:0] i_cause,
  input  logic            i_ret,
`ifdef CSR_COUNTERS_EN
  input  logic            i_retire,
`endif
  output logic            o_hit,
  output logic [XLEN-1:0] o_rdata,
  output logic [XLEN-1:0] o_mtvec,
  output logic [XLEN-1:0] o_mepc
);
  logic r_mie, r_mpie;
  logic [XLEN-1:0] r_mtvec, r_mepc, r_mcause, r_mscratch, w_wdata;
  logic w_we;
`ifdef CSR_COUNTERS_EN
  logic [XLEN-1:0] r_mcycle, r_minstret;
`endif
  always_comb begin
    o_hit = 1'b1;
    o_rdata = '0;
    case (i_addr)
      CSR_MSTATUS:  o_rdata = XLEN'({r_mpie, 3'b000, r_mie, 3'b000});
      CSR_MTVEC:    o_rdata = r_mtvec;
      CSR_MSCRATCH: o_rdata = r_mscratch;
      CSR_MEPC:     o_rdata = r_mepc;
      CSR_MCAUSE:   o_rdata = r_mcause;
`ifdef CSR_COUNTERS_EN
      CSR_MCYCLE:   o_rdata = r_mcycle;
      CSR_MINSTRET: o_rdata = r_minstret;
`endif
      default:      o_hit = 1'b0;
    endcase
  end
  // set/clear with a zero source register is a pure read
  assign w_we = i_en & (i_op == CSR_RW | ~i_zero);
  assign w_wdata = i_op == CSR_RW ? i_opnd : i_op == CSR_RS ? o_rdata | i_opnd : o_rdata & ~i_opnd;
  assign o_mtvec = r_mtvec;
  assign o_mepc = r_mepc;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mie <= 1'b0;
      r_mpie <= 1'b0;
      r_mtvec <= MTVEC_RST & ~XLEN'(3);
      r_mepc <= '0;
      r_mcause <= '0;
      r_mscratch <= '0;
`ifdef CSR_COUNTERS_EN
      r_mcycle <= '0;
      r_minstret <= '0;
`endif
    end else begin
      if (w_we && i_addr == CSR_MSTATUS) begin
        r_mie <= w_wdata[3];
        r_mpie <= w_wdata[7];
      end else if (i_trap) begin
        r_mpie <= r_mie;
        r_mie <= 1'b0;
      end else if (i_ret) begin
        r_mie <= r_mpie;
        r_mpie <= 1'b1;
      end
      if (w_we && i_addr == CSR_MTVEC) r_mtvec <= w_wdata & ~XLEN'(3);
      if (w_we && i_addr == CSR_MSCRATCH) r_mscratch <= w_wdata;
      if (w_we && i_addr == CSR_MEPC) r_mepc <= w_wdata & ~XLEN'(3);
      else if (i_trap) r_mepc <= i_epc & ~XLEN'(3);
      if (w_we && i_addr == CSR_MCAUSE) r_mcause <= w_wdata;
      else if (i_trap) r_mcause <= i_cause;
`ifdef CSR_COUNTERS_EN
      r_mcycle <= w_we && i_addr == CSR_MCYCLE ? w_wdata : r_mcycle + 1'b1;
      r_minstret <= w_we && i_addr == CSR_MINSTRET ? w_wdata : r_minstret + XLEN'(i_retire);
`endif
    end
  end
endmodule

// File: rtl/trap_csr_ctrl.sv
// trap_csr_ctrl: instruction classifier and trap FSM (IDLE/TRAP/REDIR/RET) driving stall, flush and PC redirect
// Ports: valid_i/op_code/funct3/imm12/zimm/pc_i/rs1_data = decode slot; csr_rdata/csr_we_rd = CSR result to rd;
//        busy_o = stall; flush_o/redirect_o/redirect_pc = PC redirect; illegal_o = illegal seen this cycle.
// Optional mcycle/minstret counters enabled by defining CSR_COUNTERS_EN.
module trap_csr_ctrl
  import rv_trap_pkg::*;
#(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] MTVEC_RST = 'h100,
  parameter int ILLEGAL_CAUSE = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_i,
  input  logic [6:0]      op_code,
  input  logic [2:0]      funct3,
  input  logic [11:0]     imm12,
  input  logic [4:0]      zimm,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] csr_rdata,
  output logic            csr_we_rd,
  output logic            busy_o,
  output logic            flush_o,
  output logic            redirect_o,
  output logic [XLEN-1:0] redirect_pc,
  output logic            illegal_o
);
  state_e r_state;
  logic [XLEN-1:0] r_pc, r_cause, w_cause, w_rdata, w_mtvec, w_mepc, w_opnd;
  logic w_act, w_sys, w_ecall, w_ebreak, w_mret, w_csr, w_hit, w_ill, w_trap, w_csr_en;
  // reset also masks the combinational outputs so everything reads 0 while rst is high
  assign w_act = valid_i & (r_state == IDLE) & ~rst;
  assign w_sys = op_code == OP_SYSTEM;
  assign w_ecall = w_sys & funct3 == F3_PRIV & imm12 == F12_ECALL;
  assign w_ebreak = w_sys & funct3 == F3_PRIV & imm12 == F12_EBREAK;
  assign w_mret = w_sys & funct3 == F3_PRIV & imm12 == F12_MRET;
  assign w_csr = w_sys & funct3[1:0] != 2'b00;
  // funct3 x00 on SYSTEM is only legal as ECALL/EBREAK/MRET; 100 is always illegal
  assign w_ill = ~legal_op(op_code) | (w_sys & funct3[1:0] == 2'b00 & ~(w_ecall | w_ebreak | w_mret)) |
                 (w_csr & ~w_hit);
  assign w_trap = w_act & (w_ill | w_ecall | w_ebreak);
  assign w_cause = w_ill ? XLEN'(ILLEGAL_CAUSE) : w_ebreak ? XLEN'(CAUSE_BREAK) : XLEN'(CAUSE_ECALL);
  assign w_csr_en = w_act & w_csr & w_hit;
  assign w_opnd = funct3[2] ? XLEN'(zimm) : rs1_data;
  assign illegal_o = w_act & w_ill;
  assign csr_we_rd = w_csr_en;
  assign csr_rdata = w_csr_en ? w_rdata : '0;
  assign busy_o = r_state != IDLE;
  assign redirect_o = r_state == REDIR | r_state == RET;
  assign flush_o = redirect_o;
  assign redirect_pc = r_state == REDIR ? w_mtvec : r_state == RET ? w_mepc : '0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_pc <= '0;
      r_cause <= '0;
    end else begin
      r_state <= r_state == IDLE ? (w_trap ? TRAP : w_act & w_mret ? RET : IDLE) :
                 r_state == TRAP ? REDIR : IDLE;
      if (w_trap) begin
        r_pc <= pc_i;
        r_cause <= w_cause;
      end
    end
  end
  csr_file #(.XLEN(XLEN), .MTVEC_RST(MTVEC_RST)) u_csr (
    .clk(clk),
    .rst(rst),
    .i_addr(imm12),
    .i_en(w_csr_en),
    .i_op(funct3[1:0]),
    .i_opnd(w_opnd),
    .i_zero(zimm == 5'd0),
    .i_trap(r_state == TRAP),
    .i_epc(r_pc),
    .i_cause(r_cause),
    .i_ret(r_state == RET),
`ifdef CSR_COUNTERS_EN
    .i_retire(w_act & ~w_trap),
`endif
    .o_hit(w_hit),
    .o_rdata(w_rdata),
    .o_mtvec(w_mtvec),
    .o_mepc(w_mepc)
  );
endmodule

// File: tb/tb_trap_csr_ctrl.sv
// tb_trap_csr_ctrl: directed plus randomized checks of trap_csr_ctrl against an architectural model
module tb_trap_csr_ctrl;
  logic clk = 1'b0, rst = 1'b1, valid_i = 1'b0;
  logic [6:0] op_code = '0;
  logic [2:0] funct3 = '0;
  logic [11:0] imm12 = '0;
  logic [4:0] zimm = '0;
  logic [31:0] pc_i = '0, rs1_data = '0, csr_rdata, redirect_pc;
  logic csr_we_rd, busy_o, flush_o, redirect_o, illegal_o;
  always #5 clk = ~clk;
  trap_csr_ctrl dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .op_code(op_code), .funct3(funct3), .imm12(imm12),
    .zimm(zimm), .pc_i(pc_i), .rs1_data(rs1_data), .csr_rdata(csr_rdata), .csr_we_rd(csr_we_rd),
    .busy_o(busy_o), .flush_o(flush_o), .redirect_o(redirect_o), .redirect_pc(redirect_pc),
    .illegal_o(illegal_o)
  );
  typedef struct packed {logic redir; logic [31:0] pc;} pend_t;
  pend_t pq[$];
  logic [31:0] m_mst, m_mtvec, m_mepc, m_mcause, m_mscr, m_cyc, m_ins, obs;
  logic obs_ill, wr_cyc, wr_ins;
  logic [6:0] norm_ops [9] = '{7'd3, 7'd35, 7'd51, 7'd99, 7'd19, 7'd111, 7'd103, 7'd55, 7'd23};
  logic [11:0] sys_imms [11] = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'hB00, 12'hB02,
                                 12'h000, 12'h001, 12'h302, 12'h7C0};
  int n_vec = 0, n_err = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] csr_rd(input logic [11:0] a, output logic ok);
    ok = 1'b1;
    case (a)
      12'h300: return m_mst;
      12'h305: return m_mtvec;
      12'h340: return m_mscr;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
`ifdef CSR_COUNTERS_EN
      12'hB00: return m_cyc;
      12'hB02: return m_ins;
`endif
      default: begin
        ok = 1'b0;
        return 32'h0;
      end
    endcase
  endfunction
  task automatic csr_wr(input logic [11:0] a, input logic [31:0] v);
    case (a)
      12'h300: m_mst = v & 32'h88;
      12'h305: m_mtvec = v & ~32'h3;
      12'h340: m_mscr = v;
      12'h341: m_mepc = v & ~32'h3;
      12'h342: m_mcause = v;
      12'hB00: begin m_cyc = v; wr_cyc = 1'b1; end
      12'hB02: begin m_ins = v; wr_ins = 1'b1; end
      default: ;
    endcase
  endtask
  task automatic model_reset;
    m_mst = 0; m_mtvec = 32'h100; m_mepc = 0; m_mcause = 0; m_mscr = 0; m_cyc = 0; m_ins = 0;
    pq.delete();
  endtask
  // entered at a falling edge; drives one decode slot, checks it, advances the model, leaves at the next falling edge
  task automatic step(input logic v, input logic [6:0] op, input logic [2:0] f3, input logic [11:0] imm,
                      input logic [4:0] z, input logic [31:0] pc, input logic [31:0] rs);
    logic [31:0] e_rd, e_rpc, old, opnd;
    logic e_we, e_ill, e_busy, e_redir, ok, ecall, ebrk, mret, retire;
    pend_t p;
    e_rd = 0; e_rpc = 0; e_we = 0; e_ill = 0; e_busy = 0; e_redir = 0;
    ecall = 0; ebrk = 0; mret = 0; retire = 0; wr_cyc = 0; wr_ins = 0;
    valid_i = v; op_code = op; funct3 = f3; imm12 = imm; zimm = z; pc_i = pc; rs1_data = rs;
    #1;
    if (pq.size() != 0) begin
      p = pq.pop_front();
      e_busy = 1; e_redir = p.redir; e_rpc = p.pc;
    end else if (v) begin
      if (!(op inside {norm_ops, 7'd115})) e_ill = 1;
      else if (op == 7'd115 && f3[1:0] == 2'b00) begin
        if (f3 == 0 && imm == 12'h000) ecall = 1;
        else if (f3 == 0 && imm == 12'h001) ebrk = 1;
        else if (f3 == 0 && imm == 12'h302) mret = 1;
        else e_ill = 1;
      end else if (op == 7'd115) begin
        old = csr_rd(imm, ok);
        if (!ok) e_ill = 1;
        else begin
          e_we = 1; e_rd = old;
          opnd = f3[2] ? {27'b0, z} : rs;
          if (f3[1:0] == 2'b01) csr_wr(imm, opnd);
          else if (z != 0) csr_wr(imm, f3[1:0] == 2'b10 ? (old | opnd) : (old & ~opnd));
        end
      end
      if (e_ill || ecall || ebrk) begin
        m_mepc = pc & ~32'h3;
        m_mcause = e_ill ? 32'd2 : ebrk ? 32'd3 : 32'd11;
        m_mst = m_mst[3] ? 32'h80 : 32'h0;
        pq.push_back(pend_t'{1'b0, 32'h0});
        pq.push_back(pend_t'{1'b1, m_mtvec});
      end else begin
        retire = 1;
        if (mret) begin
          pq.push_back(pend_t'{1'b1, m_mepc});
          m_mst = m_mst[7] ? 32'h88 : 32'h80;
        end
      end
    end
    obs = csr_rdata; obs_ill = illegal_o;
    chk("csr_rdata", csr_rdata, e_rd);
    chk("csr_we_rd", {31'b0, csr_we_rd}, {31'b0, e_we});
    chk("illegal_o", {31'b0, illegal_o}, {31'b0, e_ill});
    chk("busy_o", {31'b0, busy_o}, {31'b0, e_busy});
    chk("flush_o", {31'b0, flush_o}, {31'b0, e_redir});
    chk("redirect_o", {31'b0, redirect_o}, {31'b0, e_redir});
    chk("redirect_pc", redirect_pc, e_rpc);
    if (!wr_cyc) m_cyc++;
    if (!wr_ins && retire) m_ins++;
    @(negedge clk);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 7'd0, 3'd0, 12'h0, 5'd0, 32'h0, 32'h0);
  endtask
  task automatic rd(input logic [11:0] a);
    step(1'b1, 7'd115, 3'b010, a, 5'd0, 32'h0, 32'h0);
  endtask
  task automatic do_reset;
    rst = 1'b1; valid_i = 1'b0;
    #1;
    chk("rst_rdata", csr_rdata, 0);
    chk("rst_we", {31'b0, csr_we_rd}, 0);
    chk("rst_busy", {31'b0, busy_o}, 0);
    chk("rst_flush", {31'b0, flush_o}, 0);
    chk("rst_redir", {31'b0, redirect_o}, 0);
    chk("rst_rpc", redirect_pc, 0);
    chk("rst_ill", {31'b0, illegal_o}, 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask
  initial begin
    logic [31:0] a;
    logic [6:0] op;
    logic [2:0] f3;
    logic [11:0] imm;
    @(negedge clk);
    do_reset();
    rd(12'h305);
    chk("mtvec_rst", obs, 32'h100);
    step(1'b1, 7'd103, 3'd0, 12'h0, 5'd1, 32'h40, 32'h0);
    step(1'b1, 7'd0, 3'd0, 12'h0, 5'd0, 32'h40, 32'h0);
    chk("ill_op0", {31'b0, obs_ill}, 1);
    idle(2);
    rd(12'h341);
    chk("mepc_ill", obs, 32'h40);
    rd(12'h342);
    chk("mcause_ill", obs, 32'd2);
    step(1'b1, 7'd115, 3'b001, 12'h305, 5'd1, 32'h0, 32'h203);
    rd(12'h305);
    chk("mtvec_wr", obs, 32'h200);
    step(1'b1, 7'd115, 3'b110, 12'h300, 5'd8, 32'h0, 32'h0);
    step(1'b1, 7'd115, 3'b000, 12'h000, 5'd0, 32'h80, 32'h0);
    idle(2);
    rd(12'h342);
    chk("mcause_ecall", obs, 32'd11);
    rd(12'h300);
    chk("mstatus_ecall", obs, 32'h80);
    step(1'b1, 7'd115, 3'b110, 12'h300, 5'd8, 32'h0, 32'h0);
    step(1'b1, 7'd115, 3'b000, 12'h001, 5'd0, 32'h94, 32'h0);
    step(1'b1, 7'd115, 3'b001, 12'h340, 5'd1, 32'h0, 32'hDEAD);
    step(1'b1, 7'd115, 3'b001, 12'h340, 5'd1, 32'h0, 32'hBEEF);
    step(1'b1, 7'd115, 3'b000, 12'h302, 5'd0, 32'h0, 32'h0);
    step(1'b1, 7'd115, 3'b001, 12'h340, 5'd1, 32'h0, 32'hCAFE);
    rd(12'h300);
    chk("mstatus_mret", obs, 32'h88);
    rd(12'h340);
    chk("mscratch_busy", obs, 32'h0);
    step(1'b1, 7'd115, 3'b001, 12'h340, 5'd1, 32'h0, 32'hFF);
    step(1'b1, 7'd115, 3'b111, 12'h340, 5'h0F, 32'h0, 32'h0);
    rd(12'h340);
    chk("mscratch_rc", obs, 32'hF0);
    step(1'b1, 7'd115, 3'b001, 12'h7C0, 5'd1, 32'hC0, 32'h5);
    chk("ill_7c0", {31'b0, obs_ill}, 1);
    idle(2);
`ifdef CSR_COUNTERS_EN
    rd(12'hB00);
    a = obs;
    idle(4);
    rd(12'hB00);
    chk("mcycle_delta", obs - a, 32'd5);
`else
    rd(12'hB00);
    chk("ill_b00", {31'b0, obs_ill}, 1);
    idle(2);
`endif
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: begin op = norm_ops[$urandom_range(0, 8)]; f3 = 3'($urandom); imm = 12'($urandom); end
        4: begin op = 7'($urandom); f3 = 3'($urandom); imm = 12'($urandom); end
        default: begin
          op = 7'd115;
          f3 = 3'($urandom);
          imm = $urandom_range(0, 11) == 11 ? 12'($urandom) : sys_imms[$urandom_range(0, 10)];
        end
      endcase
      step($urandom_range(0, 9) != 0, op, f3, imm, 5'($urandom_range(0, 3) == 0 ? 0 : $urandom),
           $urandom, $urandom);
    end
    idle(3);
    step(1'b1, 7'd0, 3'd0, 12'h0, 5'd0, 32'h140, 32'h0);
    chk("busy_trap", {31'b0, busy_o}, 1);
    do_reset();
    rd(12'h341);
    chk("mepc_abort", obs, 32'h0);
    rd(12'h305);
    chk("mtvec_after_rst", obs, 32'h100);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/trap_csr_ctrl.md
Name: trap_csr_ctrl

Overview:
- Sequential successor to the combinational main decoder.
- Sits beside decode and classifies each valid instruction as normal, CSR access, ECALL/EBREAK, MRET or illegal.
- Owns the machine-mode CSRs and a trap FSM that stalls, flushes and redirects the fetch PC.
- Parametrised in XLEN and trap-vector reset value; optional cycle/instret counters.

Parameters:
XLEN, 32, datapath/CSR width
MTVEC_RST, 32'h0000_0100, reset value of mtvec
ILLEGAL_CAUSE, 2, mcause code written on illegal instruction/CSR

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
valid_i  in  1  decode slot holds a real instruction
op_code  in  7  instruction[6:0]
funct3  in  3  instruction[14:12]
imm12  in  12  instruction[31:20] (CSR address / funct12)
zimm  in  5  instruction[19:15] (rs1 index / CSR immediate)
pc_i  in  XLEN  PC of decode instruction
rs1_data  in  XLEN  register operand for CSRRW/S/C
csr_rdata  out  XLEN  old CSR value, written to rd
csr_we_rd  out  1  rd write-enable for CSR instruction
busy_o  out  1  FSM not IDLE; upstream must stall
flush_o  out  1  kill fetch/decode instructions
redirect_o  out  1  load redirect_pc into PC
redirect_pc  out  XLEN  trap target or mepc
illegal_o  out  1  illegal detected this cycle

Behaviour:
- Reset: all outputs 0. Registers: state=IDLE, mstatus=0, mtvec=MTVEC_RST, mepc=0, mcause=0, mscratch=0. Reset mid-trap aborts to IDLE without completing register updates.
- Legal opcodes: 3, 35, 51, 99, 19, 111, 103, 55, 23, 115. Any other opcode with valid_i in IDLE is illegal.
- CSRs: mstatus 0x300 (MIE bit3, MPIE bit7; other bits read 0), mtvec 0x305 (bits[1:0] forced 0), mscratch 0x340, mepc 0x341 (bits[1:0] forced 0), mcause 0x342.
- Any other CSR address, or funct3=100, is illegal.
- CSR op (op 115, funct3 ≠ 000) in IDLE:
  - csr_rdata = old value (combinational); csr_we_rd=1.
  - Write at the next clock edge. Operand = rs1_data for funct3 0xx, zero-extended zimm for 1xx.
  - RW writes the operand; RS ORs it in; RC clears its bits.
  - RS/RC with zimm==0 perform no write.
- Trap FSM states: IDLE, TRAP, REDIR, RET.
  - IDLE → TRAP on valid_i with illegal (cause ILLEGAL_CAUSE), ECALL (op 115, f3 0, imm12 0x000, cause 11) or EBREAK (imm12 0x001, cause 3). illegal_o=1 only in the detection cycle for illegal instructions.
  - TRAP (1 cycle): mepc←pc_i captured at detection; mcause←cause; MPIE←MIE; MIE←0.
  - REDIR (1 cycle): redirect_o=1, flush_o=1, redirect_pc=mtvec; → IDLE.
  - IDLE → RET on MRET (op 115, f3 0, imm12 0x302).
  - RET (1 cycle): redirect_o=1, flush_o=1, redirect_pc=mepc; MIE←MPIE, MPIE←1; → IDLE.
- Trap latency is 2 cycles from detection to redirect; MRET latency is 1 cycle.
- busy_o=1 in TRAP/REDIR/RET. valid_i is ignored while busy (no CSR write, no new trap).
- All CSR arithmetic is XLEN-wide; the 5-bit zimm is zero-extended.

Optional Feature:
- Macro: CSR_COUNTERS_EN.
- Defined: adds mcycle 0xB00 and minstret 0xB02, XLEN-wide, wrap-around, reset 0, both writable via CSR ops.
  - mcycle increments every cycle.
  - minstret increments on valid_i in IDLE that does not start a trap.
  - A CSR write to a counter overrides that cycle's increment.
- Undefined: both addresses are illegal (cause ILLEGAL_CAUSE).

Decomposition:
- Package rv_trap_pkg holds:
  - opcode localparams (OP_LOAD=3 … OP_SYSTEM=115);
  - CSR address constants;
  - cause codes 2/3/11;
  - state enum {IDLE, TRAP, REDIR, RET};
  - funct3 CSR op codes.
- One sub-module, csr_file: register storage, read mux, RW/RS/RC write logic and optional counters.
- trap_csr_ctrl keeps opcode classification and the FSM.

Test Plan:
- Reset, then read mtvec via CSRRS zimm=0 → csr_rdata=0x100, no write, csr_we_rd=1.
- Opcode 103 at pc 0x40 → no trap. Opcode 7'b0000000 at pc 0x40 → illegal_o=1; busy two cycles; REDIR redirect_pc=0x100; mepc=0x40, mcause=2.
- CSRRW mtvec with rs1_data 0x203 → reads back 0x200. Then ECALL at pc 0x80 → redirect 0x200, mcause=11, MIE=0, MPIE=old MIE.
- MIE=1, EBREAK, then MRET → RET redirect_pc=mepc; mstatus MIE=1, MPIE=1. valid_i pulses while busy cause no CSR change.
- CSRRC mscratch=0xFF with zimm=0x0F → 0xF0. CSR address 0x7C0 → illegal trap.
- With CSR_COUNTERS_EN: read mcycle twice 5 cycles apart → difference 5. Without it, address 0xB00 → illegal trap. Assert rst during TRAP → state IDLE, all outputs 0 immediately.
